// File: rtl/action_arbiter.sv
// action_arbiter: serialises sleep/awake/feed/play requests into one
// valid/ready command stream with round-robin grant and cooldown lockout.
module action_arbiter #(
  parameter int COOLDOWN = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_sleep,
  input  logic       req_awake,
  input  logic       req_feed,
  input  logic       req_play,
  input  logic       test_mode,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready,
  output logic [3:0] pending,
  output logic       cooldown_act,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COOL
  } state_t;

  localparam logic [CNT_W-1:0] CLOAD =
    (COOLDOWN == 0) ? '0 : CNT_W'(COOLDOWN - 1);

  state_t           state, state_nx;
  logic [1:0]       rr, rr_nx;
  logic [1:0]       gidx, gidx_nx;
  logic [1:0]       sel, idx;
  logic             found;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       req, clr, lat, drop, pend_nx;
  logic             acc;
  logic             valid_nx;
  logic [2:0]       code_nx;
  logic [2:0]       ndrop;
  logic [8:0]       dsum;
  logic [7:0]       drop_nx;

  assign req = {req_play, req_feed, req_awake, req_sleep};
  assign acc = (state == ISSUE) && cmd_valid && cmd_ready;
  assign cooldown_act = (state == COOL);

  // A pulse on a bit being accepted this cycle is a fresh request.
  always_comb begin
    clr = '0;
    if (acc) clr[gidx] = 1'b1;
    drop[0] = req[0] & (req[1] | (pending[0] & ~clr[0]));
    drop[1] = req[1] & pending[1] & ~clr[1];
    drop[2] = req[2] & pending[2] & ~clr[2];
    drop[3] = req[3] & pending[3] & ~clr[3];
    lat = pending | req;
    if (req[1])      lat[0] = 1'b0;
    else if (req[0]) lat[1] = 1'b0;
    pend_nx = lat & ~(clr & ~req);
  end

  always_comb begin
    ndrop = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    dsum = {1'b0, drop_cnt} + 9'(ndrop);
    drop_nx = dsum[8] ? 8'hff : dsum[7:0];
  end

  always_comb begin
    sel = rr;
    idx = rr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = rr + 2'(i);
      if (!found && pending[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    rr_nx = rr;
    gidx_nx = gidx;
    cnt_nx = cnt;
    valid_nx = cmd_valid;
    code_nx = cmd_code;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          gidx_nx = sel;
          code_nx = 3'(sel) + 3'd1;
          valid_nx = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (acc) begin
          rr_nx = gidx + 2'd1;
          valid_nx = 1'b0;
          code_nx = 3'd0;
          if (COOLDOWN == 0 || test_mode) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = CLOAD;
            state_nx = COOL;
          end
        end else if (!lat[gidx]) begin
          // offer cancelled by the sleep/awake override
          valid_nx = 1'b0;
          code_nx = 3'd0;
          state_nx = IDLE;
        end
      end
      COOL: begin
        if (test_mode || cnt == '0) state_nx = IDLE;
        else cnt_nx = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr <= 2'd0;
      gidx <= 2'd0;
      cnt <= '0;
      cmd_valid <= 1'b0;
      cmd_code <= 3'd0;
      pending <= 4'd0;
      drop_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      rr <= rr_nx;
      gidx <= gidx_nx;
      cnt <= cnt_nx;
      cmd_valid <= valid_nx;
      cmd_code <= code_nx;
      pending <= pend_nx;
      drop_cnt <= drop_nx;
    end
  end

endmodule

// File: tb/tb_action_arbiter.sv
// tb_action_arbiter: directed tests for action_arbiter
// with COOLDOWN=4.
module tb_action_arbiter;

  logic       clk;
  logic       rst;
  logic       req_sleep, req_awake, req_feed, req_play;
  logic       test_mode;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic [3:0] pending;
  logic       cooldown_act;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [2:0] codes [0:3];
  int ncodes;

  action_arbiter #(.COOLDOWN(4), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .req_sleep(req_sleep),
    .req_awake(req_awake),
    .req_feed(req_feed),
    .req_play(req_play),
    .test_mode(test_mode),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .cmd_ready(cmd_ready),
    .pending(pending),
    .cooldown_act(cooldown_act),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] m);
    {req_play, req_feed, req_awake, req_sleep} = m;
  endtask

  task automatic pulse(input logic [3:0] m);
    set_req(m);
    tick();
    set_req(4'b0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(4'b0000);
    cmd_ready = 1'b0;
    test_mode = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic collect(input int n);
    ncodes = 0;
    for (int k = 0; k < 4; k++) codes[k] = 3'd0;
    for (int c = 0; c < 40 && ncodes < n; c++) begin
      tick();
      if (cmd_valid && cmd_ready) begin
        codes[ncodes] = cmd_code;
        ncodes++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %0b exp 0", cmd_valid);
    end
    checks++;
    if (cmd_code !== 3'd0) begin
      errors++;
      $display("FAIL rst_code got %0d exp 0", cmd_code);
    end
    checks++;
    if (pending !== 4'd0) begin
      errors++;
      $display("FAIL rst_pending got %b exp 0000", pending);
    end
    checks++;
    if (cooldown_act !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_cool_drop got %0b/%0d exp 0/0",
               cooldown_act, drop_cnt);
    end
    pulse(4'b0100);
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd3) begin
      errors++;
      $display("FAIL pre_rst_issue got %0b/%0d exp 1/3",
               cmd_valid, cmd_code);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 || pending !== 4'd0) begin
      errors++;
      $display("FAIL async_rst got %0b/%0d/%b exp 0/0/0000",
               cmd_valid, cmd_code, pending);
    end
    #1 rst = 1'b0;
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle got %0b exp 0", cmd_valid);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    cmd_ready = 1'b1;
    pulse(4'b0100);
    checks++;
    if (cmd_valid !== 1'b0 || pending !== 4'b0100) begin
      errors++;
      $display("FAIL single_latch got %0b/%b exp 0/0100",
               cmd_valid, pending);
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd3) begin
      errors++;
      $display("FAIL single_offer got %0b/%0d exp 1/3",
               cmd_valid, cmd_code);
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 || pending !== 4'd0) begin
      errors++;
      $display("FAIL single_accept got %0b/%0d/%b exp 0/0/0000",
               cmd_valid, cmd_code, pending);
    end
    n = 0;
    for (int c = 0; c < 10 && cooldown_act; c++) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL single_cooldown got %0d exp 4", n);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    test_mode = 1'b1;
    cmd_ready = 1'b1;
    pulse(4'b1101);
    collect(3);
    checks++;
    if (codes[0] !== 3'd1 || codes[1] !== 3'd3 || codes[2] !== 3'd4) begin
      errors++;
      $display("FAIL rr_first got %0d,%0d,%0d exp 1,3,4",
               codes[0], codes[1], codes[2]);
    end
    pulse(4'b1001);
    collect(2);
    checks++;
    if (codes[0] !== 3'd1 || codes[1] !== 3'd4) begin
      errors++;
      $display("FAIL rr_from_sleep got %0d,%0d exp 1,4",
               codes[0], codes[1]);
    end
    pulse(4'b0100);
    collect(1);
    checks++;
    if (codes[0] !== 3'd3) begin
      errors++;
      $display("FAIL rr_feed got %0d exp 3", codes[0]);
    end
    pulse(4'b1001);
    collect(2);
    checks++;
    if (codes[0] !== 3'd4 || codes[1] !== 3'd1) begin
      errors++;
      $display("FAIL rr_from_play got %0d,%0d exp 4,1",
               codes[0], codes[1]);
    end
    checks++;
    if (cooldown_act !== 1'b0) begin
      errors++;
      $display("FAIL rr_no_cool got %0b exp 0", cooldown_act);
    end
    test_mode = 1'b0;
    cmd_ready = 1'b0;
  endtask

  task automatic test_drops();
    do_reset();
    pulse(4'b0100);
    pulse(4'b0100);
    checks++;
    if (drop_cnt !== 8'd1 || pending !== 4'b0100) begin
      errors++;
      $display("FAIL drop_one got %0d/%b exp 1/0100", drop_cnt, pending);
    end
    set_req(4'b0100);
    repeat (253) tick();
    checks++;
    if (drop_cnt !== 8'd254) begin
      errors++;
      $display("FAIL drop_254 got %0d exp 254", drop_cnt);
    end
    tick();
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_255 got %0d exp 255", drop_cnt);
    end
    repeat (46) tick();
    set_req(4'b0000);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_sat got %0d exp 255", drop_cnt);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    pulse(4'b0011);
    checks++;
    if (pending !== 4'b0010 || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL conflict_same got %b/%0d exp 0010/1",
               pending, drop_cnt);
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd2) begin
      errors++;
      $display("FAIL conflict_offer got %0b/%0d exp 1/2",
               cmd_valid, cmd_code);
    end
    pulse(4'b0001);
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 ||
        pending !== 4'b0001 || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL conflict_withdraw got %0b/%0d/%b/%0d exp 0/0/0001/1",
               cmd_valid, cmd_code, pending, drop_cnt);
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin
      errors++;
      $display("FAIL conflict_regrant got %0b/%0d exp 1/1",
               cmd_valid, cmd_code);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++;
    if (pending !== 4'd0 || cooldown_act !== 1'b1) begin
      errors++;
      $display("FAIL conflict_accept got %b/%0b exp 0000/1",
               pending, cooldown_act);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    pulse(4'b0001);
    tick();
    for (int i = 0; i < 10; i++) begin
      req_play = (i == 3);
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin
        errors++;
        $display("FAIL bp_stable[%0d] got %0b/%0d exp 1/1",
                 i, cmd_valid, cmd_code);
      end
    end
    req_play = 1'b0;
    checks++;
    if (pending !== 4'b1001) begin
      errors++;
      $display("FAIL bp_latched got %b exp 1001", pending);
    end
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL bp_accept got %0b/%b exp 0/1000", cmd_valid, pending);
    end
    n = 0;
    for (int c = 0; c < 20 && !cmd_valid; c++) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5 || cmd_code !== 3'd4) begin
      errors++;
      $display("FAIL bp_next got %0d cyc code %0d exp 5 cyc code 4",
               n, cmd_code);
    end
    cmd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_req(4'b0000);
    cmd_ready = 1'b0;
    test_mode = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_drops();
    test_conflict();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
